// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared definitions for the 5-stage core's hazard and
//               forwarding units: register-index width, hazard FSM state
//               encodings and forwarding select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Register index width (8 architectural registers, r0 hard-wired to zero)
    localparam int REG_W = 3;

    // Hazard FSM state encodings
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    // Forwarding mux select codes, shared with the forwarding unit
    localparam logic [1:0] FORWARD_NONE    = 2'b00;
    localparam logic [1:0] FORWARD_EX_RES  = 2'b10;
    localparam logic [1:0] FORWARD_MEM_RES = 2'b11;
    localparam logic [1:0] FORWARD_WB_RES  = 2'b01;

endpackage : core_pkg
`default_nettype wire

// File: rtl/hazard_unit_raw_compare.sv
`default_nettype none
// ============================================================================
// Module      : raw_compare
// Description : Read-after-write match for one source operand against one
//               downstream pipeline stage's destination.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_compare
    import core_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_used,
    input  logic [REG_W-1:0] i_dest,
    input  logic             i_wb_en,
    output logic             o_match
);

    // r0 is never a real dependency, so a zero source can never match
    assign o_match = i_used & (i_src != '0) & (i_src == i_dest) & i_wb_en;

endmodule : raw_compare
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller. Detects load-use / RAW hazards,
//               fixed-latency memory waits and taken-branch squashes, and
//               drives freeze / bubble / flush controls plus a saturating
//               stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import core_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frwd_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_is_ld,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_access,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    input  logic             branch_taken,
    input  logic             stat_clr,
    output logic             hazard_en,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt
);

    // A single-cycle memory never needs the wait state
    localparam logic       c_WAIT_EN   = (MEM_LAT >= 2);
    localparam logic [3:0] c_WAIT_INIT = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;

    logic             r_frwd_q;
    logic [0:0]       r_state;
    logic [3:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [0:0]       w_next_state;
    logic [3:0]       w_next_wait;
    logic             w_pc_freeze;
    logic             w_if_id_freeze;
    logic             w_id_ex_bubble;
    logic             w_if_id_flush;
    logic             w_pipe_freeze;

    // ------------------------------------------------------------------
    // RAW detection: 2 sources x 3 stages; bit index = src*3 + stage
    // (stage 0 = EX, 1 = MEM, 2 = WB)
    // ------------------------------------------------------------------
    logic [REG_W-1:0] w_src   [2];
    logic             w_used  [2];
    logic [REG_W-1:0] w_dest  [3];
    logic             w_wb_en [3];
    logic [5:0]       w_hit;
    logic             w_raw_ex;
    logic             w_raw_mem;
    logic             w_raw_wb;
    logic             w_stall_req;

    assign w_src[0]   = id_src1;
    assign w_src[1]   = id_src2;
    assign w_used[0]  = id_src1_used;
    assign w_used[1]  = id_src2_used;
    assign w_dest[0]  = ex_dest;
    assign w_dest[1]  = mem_dest;
    assign w_dest[2]  = wb_dest;
    assign w_wb_en[0] = ex_wb_en;
    assign w_wb_en[1] = mem_wb_en;
    assign w_wb_en[2] = wb_wb_en;

    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            for (genvar t = 0; t < 3; t++) begin : g_stage
                raw_compare u_raw_compare (
                    .i_src   (w_src[s]),
                    .i_used  (w_used[s]),
                    .i_dest  (w_dest[t]),
                    .i_wb_en (w_wb_en[t]),
                    .o_match (w_hit[s*3 + t])
                );
            end
        end
    endgenerate

    assign w_raw_ex  = w_hit[0] | w_hit[3];
    assign w_raw_mem = w_hit[1] | w_hit[4];
    assign w_raw_wb  = w_hit[2] | w_hit[5];

    // With forwarding only a load in EX cannot be bypassed in time;
    // without it any in-flight writer of a source must drain first.
    assign w_stall_req = r_frwd_q ? (w_raw_ex & ex_is_ld)
                                  : (w_raw_ex | w_raw_mem | w_raw_wb);

    // Forwarding mode is sampled once per cycle; reset leaves it disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frwd_q <= 1'b0;
        end else begin
            r_frwd_q <= frwd_en;
        end
    end

    // Control decode and next-state for the RUN / MEM_WAIT machine
    always_comb begin
        w_next_state   = r_state;
        w_next_wait    = r_wait_cnt;
        w_pc_freeze    = 1'b0;
        w_if_id_freeze = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_if_id_flush  = 1'b0;
        w_pipe_freeze  = 1'b0;

        if ((r_state == MEM_WAIT) && (r_wait_cnt != 4'd0)) begin
            // Memory still busy: everything holds, other requests masked
            w_pipe_freeze  = 1'b1;
            w_pc_freeze    = 1'b1;
            w_if_id_freeze = 1'b1;
            w_next_wait    = r_wait_cnt - 4'd1;
        end else if ((r_state == RUN) && mem_access && c_WAIT_EN) begin
            // First cycle of a multi-cycle memory access
            w_pipe_freeze  = 1'b1;
            w_pc_freeze    = 1'b1;
            w_if_id_freeze = 1'b1;
            w_next_wait    = c_WAIT_INIT;
            w_next_state   = MEM_WAIT;
        end else begin
            // RUN without a new memory op, or the MEM_WAIT release cycle
            // (the still-resident memory op must not retrigger a wait)
            w_next_state = RUN;
            if (branch_taken) begin
                // The ID instruction is squashed, so its stall is moot
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (w_stall_req) begin
                w_pc_freeze    = 1'b1;
                w_if_id_freeze = 1'b1;
                w_id_ex_bubble = 1'b1;
            end
        end
    end

    // FSM state and memory wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end
    end

    // Saturating count of PC-frozen cycles; clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (w_pc_freeze && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Controls are forced inactive for the whole time reset is held
    assign pc_freeze    = rst & w_pc_freeze;
    assign if_id_freeze = rst & w_if_id_freeze;
    assign id_ex_bubble = rst & w_id_ex_bubble;
    assign if_id_flush  = rst & w_if_id_flush;
    assign pipe_freeze  = rst & w_pipe_freeze;
    assign hazard_en    = ~r_frwd_q;
    assign stall_cnt    = r_stall_cnt;

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed, scoreboard-checked bench for hazard_unit. Three
//               instances (MEM_LAT = 3, 1, 5) share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    // Control vector packing: {hazard_en, pipe_freeze, pc_freeze,
    //                          if_id_freeze, id_ex_bubble, if_id_flush}
    localparam logic [5:0] N_DIS     = 6'b100000;
    localparam logic [5:0] N_EN      = 6'b000000;
    localparam logic [5:0] STALL_DIS = 6'b101110;
    localparam logic [5:0] STALL_EN  = 6'b001110;
    localparam logic [5:0] FRZ_DIS   = 6'b111100;
    localparam logic [5:0] BR_DIS    = 6'b100011;

    logic       clk = 1'b0;
    logic       rst;
    logic       frwd_en;
    logic [2:0] id_src1, id_src2, ex_dest, mem_dest, wb_dest;
    logic       id_src1_used, id_src2_used, ex_wb_en, ex_is_ld;
    logic       mem_wb_en, mem_access, wb_wb_en, branch_taken, stat_clr;

    logic        he_a, pc_a, ifz_a, bub_a, fl_a, pf_a;
    logic        he_b, pc_b, ifz_b, bub_b, fl_b, pf_b;
    logic        he_c, pc_c, ifz_c, bub_c, fl_c, pf_c;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    logic [3:0]  cnt_c;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_LAT(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .frwd_en(frwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_is_ld(ex_is_ld),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .hazard_en(he_a), .pc_freeze(pc_a), .if_id_freeze(ifz_a),
        .id_ex_bubble(bub_a), .if_id_flush(fl_a), .pipe_freeze(pf_a),
        .stall_cnt(cnt_a)
    );

    hazard_unit #(.MEM_LAT(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .frwd_en(frwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_is_ld(ex_is_ld),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .hazard_en(he_b), .pc_freeze(pc_b), .if_id_freeze(ifz_b),
        .id_ex_bubble(bub_b), .if_id_flush(fl_b), .pipe_freeze(pf_b),
        .stall_cnt(cnt_b)
    );

    hazard_unit #(.MEM_LAT(5), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .frwd_en(frwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_is_ld(ex_is_ld),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken), .stat_clr(stat_clr),
        .hazard_en(he_c), .pc_freeze(pc_c), .if_id_freeze(ifz_c),
        .id_ex_bubble(bub_c), .if_id_flush(fl_c), .pipe_freeze(pf_c),
        .stall_cnt(cnt_c)
    );

    logic [5:0] ctl_a, ctl_b, ctl_c;
    assign ctl_a = {he_a, pf_a, pc_a, ifz_a, bub_a, fl_a};
    assign ctl_b = {he_b, pf_b, pc_b, ifz_b, bub_b, fl_b};
    assign ctl_c = {he_c, pf_c, pc_c, ifz_c, bub_c, fl_c};

    typedef struct {
        string      nm;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] c;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    logic chk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Monitor: one scoreboard entry per presented cycle, compared mid-cycle
    always @(negedge clk) begin
        if (chk) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (ctl_a !== e.a) begin
                    errors++;
                    $display("FAIL %s ctl_a actual=%b required=%b", e.nm, ctl_a, e.a);
                end
                checks++;
                if (ctl_b !== e.b) begin
                    errors++;
                    $display("FAIL %s ctl_b actual=%b required=%b", e.nm, ctl_b, e.b);
                end
                checks++;
                if (ctl_c !== e.c) begin
                    errors++;
                    $display("FAIL %s ctl_c actual=%b required=%b", e.nm, ctl_c, e.c);
                end
                checks++;
                if (cnt_a !== e.cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt_a actual=%0d required=%0d", e.nm, cnt_a, e.cnt);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic clear_ins();
        id_src1 = 3'd0; id_src2 = 3'd0; id_src1_used = 1'b0; id_src2_used = 1'b0;
        ex_dest = 3'd0; ex_wb_en = 1'b0; ex_is_ld = 1'b0;
        mem_dest = 3'd0; mem_wb_en = 1'b0; mem_access = 1'b0;
        wb_dest = 3'd0; wb_wb_en = 1'b0;
        branch_taken = 1'b0; stat_clr = 1'b0;
    endtask

    // Advance to just after the next rising edge with quiet pipeline inputs
    task automatic tick();
        @(posedge clk);
        #1;
        clear_ins();
    endtask

    task automatic expect3(input string nm, input logic [5:0] ea, input logic [5:0] eb,
                           input logic [5:0] ec, input logic [3:0] ecnt);
        exp_t e;
        e.nm  = nm;
        e.a   = ea;
        e.b   = eb;
        e.c   = ec;
        e.cnt = ecnt;
        sb.push_back(e);
        chk = 1'b1;
    endtask

    task automatic load_use();
        ex_dest = 3'd3; ex_wb_en = 1'b1; ex_is_ld = 1'b1;
        id_src1 = 3'd3; id_src1_used = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        frwd_en = 1'b0;
        clear_ins();

        // Reset forces controls low regardless of requests
        tick(); branch_taken = 1'b1; mem_access = 1'b1; load_use();
        expect3("reset_forced", N_DIS, N_DIS, N_DIS, 4'd0);
        tick(); rst = 1'b1; frwd_en = 1'b1;
        expect3("post_reset", N_DIS, N_DIS, N_DIS, 4'd0);

        // Load-use with forwarding
        tick(); load_use(); id_src2 = 3'd1; id_src2_used = 1'b1;
        expect3("load_use", STALL_EN, STALL_EN, STALL_EN, 4'd0);
        tick();
        expect3("after_load_use", N_EN, N_EN, N_EN, 4'd1);
        tick(); frwd_en = 1'b0;
        ex_dest = 3'd3; ex_wb_en = 1'b1; mem_dest = 3'd3; mem_wb_en = 1'b1;
        wb_dest = 3'd3; wb_wb_en = 1'b1; id_src1 = 3'd3; id_src1_used = 1'b1;
        expect3("fwd_no_stall", N_EN, N_EN, N_EN, 4'd1);

        // No-forward chain on r2 via src2
        tick(); ex_dest = 3'd2; ex_wb_en = 1'b1; id_src2 = 3'd2; id_src2_used = 1'b1;
        expect3("raw_ex_nofwd", STALL_DIS, STALL_DIS, STALL_DIS, 4'd1);
        tick(); mem_dest = 3'd2; mem_wb_en = 1'b1; id_src2 = 3'd2; id_src2_used = 1'b1;
        expect3("raw_mem_nofwd", STALL_DIS, STALL_DIS, STALL_DIS, 4'd2);
        tick(); wb_dest = 3'd2; wb_wb_en = 1'b1; id_src2 = 3'd2; id_src2_used = 1'b1;
        expect3("raw_wb_nofwd", STALL_DIS, STALL_DIS, STALL_DIS, 4'd3);
        tick(); ex_wb_en = 1'b1; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
        id_src1_used = 1'b1; id_src2_used = 1'b1;
        expect3("r0_never", N_DIS, N_DIS, N_DIS, 4'd4);
        tick(); ex_dest = 3'd5; ex_wb_en = 1'b1; id_src1 = 3'd5;
        mem_dest = 3'd6; id_src2 = 3'd6; id_src2_used = 1'b1;
        expect3("unused_or_nowb", N_DIS, N_DIS, N_DIS, 4'd4);

        // Branch and stall in the same cycle
        tick(); ex_dest = 3'd4; ex_wb_en = 1'b1; id_src1 = 3'd4; id_src1_used = 1'b1;
        branch_taken = 1'b1;
        expect3("branch_over_stall", BR_DIS, BR_DIS, BR_DIS, 4'd4);

        // Memory waits: A=3 cycles, B=1 cycle, C=5 cycles
        tick(); mem_access = 1'b1; mem_dest = 3'd6; mem_wb_en = 1'b1;
        expect3("mem_m0", FRZ_DIS, N_DIS, FRZ_DIS, 4'd4);
        tick(); mem_access = 1'b1; mem_dest = 3'd6; mem_wb_en = 1'b1;
        expect3("mem_m1", FRZ_DIS, N_DIS, FRZ_DIS, 4'd5);
        tick(); mem_access = 1'b1; mem_dest = 3'd6; mem_wb_en = 1'b1;
        ex_dest = 3'd1; ex_wb_en = 1'b1; id_src1 = 3'd1; id_src1_used = 1'b1;
        expect3("mem_release", STALL_DIS, STALL_DIS, FRZ_DIS, 4'd6);
        tick(); mem_access = 1'b1;
        expect3("mem_b2b_start", FRZ_DIS, N_DIS, FRZ_DIS, 4'd7);
        tick(); mem_access = 1'b1;
        expect3("mem_b2b_hold", FRZ_DIS, N_DIS, N_DIS, 4'd8);
        tick();
        expect3("mem_b2b_release", N_DIS, N_DIS, N_DIS, 4'd9);

        // Reset in the second freeze cycle of a wait
        tick(); mem_access = 1'b1; frwd_en = 1'b1;
        expect3("rst_r0", FRZ_DIS, N_DIS, FRZ_DIS, 4'd9);
        tick(); mem_access = 1'b1; rst = 1'b0;
        expect3("rst_asserted", N_DIS, N_DIS, N_DIS, 4'd0);
        tick(); rst = 1'b1;
        expect3("rst_released", N_DIS, N_DIS, N_DIS, 4'd0);
        tick();
        expect3("rst_no_residual", N_EN, N_EN, N_EN, 4'd0);

        // Counter saturation and clear
        for (int i = 0; i < 20; i++) begin
            tick(); load_use();
            expect3("sat_hold", STALL_EN, STALL_EN, STALL_EN, (i > 15) ? 4'd15 : 4'(i));
        end
        tick(); load_use(); stat_clr = 1'b1;
        expect3("clr_with_stall", STALL_EN, STALL_EN, STALL_EN, 4'd15);
        tick(); load_use();
        expect3("clr_result", STALL_EN, STALL_EN, STALL_EN, 4'd0);
        tick();
        expect3("clr_resume", N_EN, N_EN, N_EN, 4'd1);
        tick();
        expect3("final_idle", N_EN, N_EN, N_EN, 4'd1);

        @(posedge clk);
        #1;
        chk = 1'b0;
        repeat (2) @(posedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_unit
`default_nettype wire
